// File: rtl/bmem_line_adapter_if.sv
// rtl/bmem_line_adapter_if.sv - cache-side and memory-side signal bundle for bmem_line_adapter
interface bmem_line_adapter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int BURST_LEN  = 4
) ();
  localparam int LINE_W = BUS_WIDTH * BURST_LEN;

  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_read;
  logic                  i_resp;
  logic [LINE_W-1:0]     i_rdata;

  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_read;
  logic                  d_write;
  logic [LINE_W-1:0]     d_wdata;
  logic                  d_resp;
  logic [LINE_W-1:0]     d_rdata;

  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BUS_WIDTH-1:0]  bmem_wdata;
  logic                  bmem_ready;
  logic [ADDR_WIDTH-1:0] bmem_raddr;
  logic [BUS_WIDTH-1:0]  bmem_rdata;
  logic                  bmem_rvalid;

  modport master (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output i_resp, i_rdata, d_resp, d_rdata,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport slave (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  i_resp, i_rdata, d_resp, d_rdata,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/bmem_line_adapter.sv
// rtl/bmem_line_adapter.sv - I/D cache line adapter onto a bursting banked memory
// Define BMEM_ADAPTER_RR_EN for round-robin arbitration instead of fixed D-over-I.
module bmem_line_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int BURST_LEN  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bmem_line_adapter_if.master bus,
  output logic                err
);
  localparam int LINE_W = BUS_WIDTH * BURST_LEN;
  localparam int OFS_W  = $clog2(LINE_W / 8);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, WR_BURST} state_e;
  typedef enum logic [1:0] {TGT_NONE, TGT_I, TGT_D} tgt_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] wbeat_q, wbeat_d;
  logic [BEAT_W-1:0] rx_beat_q;
  tgt_e              rx_tgt_q, rx_tgt;
  logic [LINE_W-1:0] rx_line_q, rx_line_d;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_out_q, d_out_q, i_resp_q, d_resp_q, err_q;
  logic              same_line, elig_i, elig_d, prefer_d, gnt_i, gnt_d;
  logic              i_acc, d_acc, wr_done, rx_first, hit_i, hit_d;
  logic              unused_lo;

  assign unused_lo = ^{bus.i_addr[OFS_W-1:0], bus.d_addr[OFS_W-1:0], bus.bmem_raddr[OFS_W-1:0]};

  // A client stays ineligible during its resp cycle: its request is still held then.
  assign same_line = (bus.i_addr[ADDR_WIDTH-1:OFS_W] == bus.d_addr[ADDR_WIDTH-1:OFS_W]);
  assign elig_i = rst_n && bus.i_read && !i_out_q && !i_resp_q && !(d_out_q && same_line);
  assign elig_d = rst_n && (bus.d_read || bus.d_write) && !d_out_q && !d_resp_q
                  && !(i_out_q && same_line);

`ifdef BMEM_ADAPTER_RR_EN
  logic last_d_q;  // set when D holds the most recent accepted grant
  assign prefer_d = !last_d_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        last_d_q <= 1'b0;
    else if (bus.bmem_ready && gnt_d)  last_d_q <= 1'b1;
    else if (bus.bmem_ready && gnt_i)  last_d_q <= 1'b0;
  end
`else
  assign prefer_d = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    wbeat_d        = wbeat_q;
    gnt_i          = 1'b0;
    gnt_d          = 1'b0;
    i_acc          = 1'b0;
    d_acc          = 1'b0;
    wr_done        = 1'b0;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_addr  = '0;
    bus.bmem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (elig_d && (!elig_i || prefer_d)) gnt_d = 1'b1;
        else if (elig_i)                     gnt_i = 1'b1;
        if (gnt_d) begin
          bus.bmem_addr = bus.d_addr;
          if (bus.d_write) begin
            bus.bmem_write = 1'b1;
            bus.bmem_wdata = bus.d_wdata[BUS_WIDTH-1:0];
            if (bus.bmem_ready) begin
              state_d = WR_BURST;
              wbeat_d = BEAT_W'(1);
            end
          end else begin
            bus.bmem_read = 1'b1;
            d_acc         = bus.bmem_ready;
          end
        end else if (gnt_i) begin
          bus.bmem_addr = bus.i_addr;
          bus.bmem_read = 1'b1;
          i_acc         = bus.bmem_ready;
        end
      end
      WR_BURST: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = bus.d_addr;
        bus.bmem_wdata = bus.d_wdata[int'(wbeat_q) * BUS_WIDTH +: BUS_WIDTH];
        if (bus.bmem_ready) begin
          wbeat_d = wbeat_q + 1'b1;
          if (wbeat_q == LAST_BEAT) begin
            state_d = IDLE;
            wbeat_d = '0;
            wr_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat 0 resolves the owner from raddr; later beats reuse the latched owner.
  assign rx_first = (rx_beat_q == '0);
  assign hit_i = i_out_q && (bus.bmem_raddr[ADDR_WIDTH-1:OFS_W] == bus.i_addr[ADDR_WIDTH-1:OFS_W]);
  assign hit_d = d_out_q && (bus.bmem_raddr[ADDR_WIDTH-1:OFS_W] == bus.d_addr[ADDR_WIDTH-1:OFS_W]);

  always_comb begin
    rx_tgt = rx_tgt_q;
    if (rx_first) rx_tgt = hit_d ? TGT_D : (hit_i ? TGT_I : TGT_NONE);
    rx_line_d = rx_line_q;
    rx_line_d[int'(rx_beat_q) * BUS_WIDTH +: BUS_WIDTH] = bus.bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wbeat_q   <= '0;
      rx_beat_q <= '0;
      rx_tgt_q  <= TGT_NONE;
      rx_line_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_out_q   <= 1'b0;
      d_out_q   <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wbeat_q  <= wbeat_d;
      i_resp_q <= 1'b0;
      d_resp_q <= wr_done;
      i_out_q  <= i_out_q | i_acc;
      d_out_q  <= d_out_q | d_acc;
      if (bus.d_read && bus.d_write) err_q <= 1'b1;
      if (bus.bmem_rvalid) begin
        rx_line_q <= rx_line_d;
        rx_tgt_q  <= rx_tgt;
        rx_beat_q <= rx_beat_q + 1'b1;
        if (rx_first && rx_tgt == TGT_NONE) err_q <= 1'b1;
        if (rx_beat_q == LAST_BEAT) begin
          rx_beat_q <= '0;
          if (rx_tgt == TGT_I) begin
            i_rdata_q <= rx_line_d;
            i_resp_q  <= 1'b1;
            i_out_q   <= 1'b0;
          end
          if (rx_tgt == TGT_D) begin
            d_rdata_q <= rx_line_d;
            d_resp_q  <= 1'b1;
            d_out_q   <= 1'b0;
          end
        end
      end else if (!rx_first) begin
        err_q     <= 1'b1;
        rx_beat_q <= '0;
      end
    end
  end

  assign bus.i_resp  = i_resp_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_resp  = d_resp_q;
  assign bus.d_rdata = d_rdata_q;
  assign err         = err_q;
endmodule

// File: doc/bmem_line_adapter.md
Name: bmem_line_adapter

Overview:
- Initiator-side adapter between the two L1 caches (I and D) and the banked memory interface.
- Accepts whole-line (256-bit) read and write requests from each cache and arbitrates between them.
- Serializes writes into 64-bit bursts and issues reads.
- Reassembles returning read bursts and routes each one to the owning cache by matching raddr. Each cache may have one read outstanding, so up to two reads are in flight and may return out of order.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides
- BUS_WIDTH, 64, memory data bus width in bits
- BURST_LEN, 4, beats per line; line width = BUS_WIDTH*BURST_LEN (256)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_addr  in  ADDR_WIDTH  I-cache line address, low 5 bits zero
- i_read  in  1  I-cache read request, held until i_resp
- i_resp  out  1  one-cycle pulse: I request complete
- i_rdata  out  256  I-cache read line, valid with i_resp, held until the next I response
- d_addr  in  ADDR_WIDTH  D-cache line address, low 5 bits zero
- d_read  in  1  D-cache read request, held until d_resp
- d_write  in  1  D-cache write request, held until d_resp
- d_wdata  in  256  D-cache write line, stable while d_write is high
- d_resp  out  1  one-cycle pulse: D request complete
- d_rdata  out  256  D-cache read line, valid with d_resp
- bmem_addr  out  ADDR_WIDTH  memory request address
- bmem_read  out  1  memory read request
- bmem_write  out  1  memory write request
- bmem_wdata  out  BUS_WIDTH  write beat
- bmem_ready  in  1  memory accepting
- bmem_raddr  in  ADDR_WIDTH  address of returning burst
- bmem_rdata  in  BUS_WIDTH  read beat
- bmem_rvalid  in  1  read beat valid
- err  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): every output is 0; all pending, outstanding and beat state is cleared; the issue FSM goes to IDLE. Any burst still in flight at memory after reset is unmatched (see rx rules).
- Client rules:
  - A cache holds read/write and addr until its resp.
  - d_read and d_write both high is a protocol violation: set err and service the write.
  - A client is "eligible" when it has a request, is not outstanding, and is not hazard-blocked.
- Hazard rule: a client is not issued while the other client has an outstanding read to the same line (addr[ADDR_WIDTH-1:5] equal).
- Issue FSM states: IDLE, WR_BURST.
  - IDLE: pick one eligible client; D wins if both are eligible.
  - Read issue: drive bmem_read=1 with bmem_addr. When bmem_ready=1 at a posedge, the request is accepted: deassert next cycle, set the client outstanding, stay IDLE.
  - Write issue: drive bmem_write=1, bmem_addr, bmem_wdata=d_wdata[63:0]. On acceptance (ready=1) go to WR_BURST with beat=1.
  - WR_BURST: hold bmem_write=1 and drive d_wdata[beat*64 +: 64]. Beat advances only on posedges where ready=1.
  - After beat 3 is accepted: deassert write, pulse d_resp next cycle, return to IDLE.
  - ready=0 stalls any beat indefinitely, with all outputs held.
- Only one bmem command at a time. A read issue is single-cycle when ready=1, so a back-to-back I-then-D read takes 2 cycles.
- Rx path:
  - Bursts are 4 contiguous rvalid beats; raddr is constant within a burst.
  - Beat 0: compare bmem_raddr with the addresses of outstanding reads and latch the target. The hazard rule guarantees at most one match.
  - Beat k goes to line[k*64 +: 64].
  - After beat 3: drive the target rdata, pulse its resp next cycle (latency: 1 cycle after the last rvalid), and clear outstanding.
  - A burst with no match sets err and is dropped; beats are still counted.
  - rvalid deasserting mid-burst sets err and resets the beat count.
- Simultaneous events: a d_resp for a write and an i_resp for a read may pulse in the same cycle. A request may be issued in the same cycle another burst is being received.
- Beat counters wrap at BURST_LEN-1 -> 0. All widths are unsigned.

Optional Feature:
- Macro BMEM_ADAPTER_RR_EN.
- Defined: round-robin arbitration. A last-grant bit toggles on each accepted issue, and the non-last client wins a tie.
- Undefined: fixed D-over-I priority as above.
- Single-client behaviour is identical either way.

Test Plan:
- I read 0x0000_1000, memory returns beats A,B,C,D -> i_resp 1 cycle after last rvalid, i_rdata = {D,C,B,A}.
- D write 0x0000_2000, d_wdata = {W3,W2,W1,W0}, with ready=0 for 2 cycles before beat 2 -> wdata sequence W0,W1,W2,W3 with no beat lost; single d_resp pulse after W3 is accepted.
- I read 0x100 and D read 0x200 issued in the same cycle; memory returns 0x200 first -> D issued first; d_resp before i_resp, each with the correct data.
- I read outstanding at 0x300 while D write requests 0x300 -> no bmem_write until i_resp; then the write issues.
- Burst with raddr 0xDEAD_0000 and nothing outstanding -> err=1, no resp pulses.
- Both clients read continuously (distinct lines), with and without BMEM_ADAPTER_RR_EN -> without: D always granted first; with: grants alternate D,I,D,I.
